// File: rtl/cr_cceip_64_sa_snap_ctrl_pkg.sv
// Shared sizing, FSM state type and helpers for the statistics-aggregator
// snapshot scheduler and readout sequencer.
package cr_cceip_64_sa_snap_ctrlPKG;

  localparam int N_CNTRS      = 64;
  localparam int CNT_W        = 50;
  localparam int IDX_W        = $clog2(N_CNTRS);
  localparam int TMR_W        = 32;
  localparam int SNAP_LAT     = 1;
  localparam int SA_OVERRUN_W = 8;
  localparam int WAIT_W       = (SNAP_LAT > 1) ? $clog2(SNAP_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    WAIT,
    READ
  } sa_snap_st_e;

  function automatic logic [SA_OVERRUN_W-1:0] sat_inc(input logic [SA_OVERRUN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cr_cceip_64_sa_snap_ctrl_if.sv
// Valid/ready export stream carrying (index, value) beats to the stats-export sink.
interface cr_cceip_64_sa_snap_ctrl_if;
  import cr_cceip_64_sa_snap_ctrlPKG::*;

  logic             exp_valid;
  logic             exp_ready;
  logic [IDX_W-1:0] exp_idx;
  logic [CNT_W-1:0] exp_data;
  logic             exp_last;

  modport master (output exp_valid, exp_idx, exp_data, exp_last, input exp_ready);
  modport slave  (input exp_valid, exp_idx, exp_data, exp_last, output exp_ready);

endinterface

// File: rtl/cr_cceip_64_sa_snap_tmr.sv
// Periodic snapshot timer: counts 0..cfg_period-1 and flags expiry on the last count.
module cr_cceip_64_sa_snap_tmr
  import cr_cceip_64_sa_snap_ctrlPKG::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [TMR_W-1:0] cfg_period,
  output logic             tmr_expire
);

  logic [TMR_W-1:0] cnt;

  // Using >= also fires immediately when the period is shrunk below the running count.
  assign tmr_expire = (cfg_period != '0) && (cnt >= cfg_period - 1'b1);

  always_ff @(posedge clk) begin
    if (rst || cfg_period == '0 || tmr_expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cr_cceip_64_sa_snap_ctrl.sv
// Snapshot scheduler: merges software/timer triggers, strobes the aggregator,
// then streams all snapshot counters out as (index, value) beats.
module cr_cceip_64_sa_snap_ctrl
  import cr_cceip_64_sa_snap_ctrlPKG::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TMR_W-1:0]        cfg_period,
  input  logic                    sw_snap_req,
  input  logic                    sw_clear_req,
  output logic                    sa_snap,
  output logic                    sa_clear_live,
  output logic [IDX_W-1:0]        rd_idx,
  input  logic [CNT_W-1:0]        rd_data,
  cr_cceip_64_sa_snap_ctrl_if.master exp,
  output logic                    busy,
  output logic [SA_OVERRUN_W-1:0] overrun_cnt
);

  sa_snap_st_e      st;
  logic             pending;
  logic             iss_done;
  logic [IDX_W-1:0] iss_idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic             tmr_expire;
  logic             trigger;
  logic             wait_done;
  logic             rd_en;
  logic             load;

  cr_cceip_64_sa_snap_tmr u_tmr (
    .clk        (clk),
    .rst        (rst),
    .cfg_period (cfg_period),
    .tmr_expire (tmr_expire)
  );

  assign trigger   = sw_snap_req | tmr_expire;
  assign rd_idx    = iss_idx;
  assign wait_done = (wait_cnt == WAIT_W'(SNAP_LAT - 1));
  // Beat 0 is loaded on the WAIT->READ edge so it is already valid on READ entry.
  assign rd_en     = (st == READ) || ((st == WAIT) && wait_done);
  assign load      = rd_en && !iss_done && (!exp.exp_valid || exp.exp_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      pending       <= 1'b0;
      overrun_cnt   <= '0;
      sa_snap       <= 1'b0;
      sa_clear_live <= 1'b0;
      busy          <= 1'b0;
      iss_idx       <= '0;
      iss_done      <= 1'b0;
      wait_cnt      <= '0;
      exp.exp_valid <= 1'b0;
      exp.exp_idx   <= '0;
      exp.exp_data  <= '0;
      exp.exp_last  <= 1'b0;
    end else begin
      sa_snap       <= 1'b0;
      sa_clear_live <= sw_clear_req;

      if (st != IDLE && trigger) begin
        if (!pending) pending <= 1'b1;
        else          overrun_cnt <= sat_inc(overrun_cnt);
      end

      // Issue index wraps back to 0 after the last counter, leaving rd_idx parked at 0.
      if (load) begin
        exp.exp_valid <= 1'b1;
        exp.exp_idx   <= iss_idx;
        exp.exp_data  <= rd_data;
        exp.exp_last  <= (iss_idx == IDX_W'(N_CNTRS - 1));
        iss_idx       <= iss_idx + 1'b1;
        if (iss_idx == IDX_W'(N_CNTRS - 1)) iss_done <= 1'b1;
      end else if (exp.exp_valid && exp.exp_ready) begin
        exp.exp_valid <= 1'b0;
        exp.exp_last  <= 1'b0;
      end

      case (st)
        IDLE: begin
          if (trigger || pending) begin
            st      <= SNAP;
            pending <= 1'b0;
            sa_snap <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SNAP: begin
          st       <= WAIT;
          wait_cnt <= '0;
          iss_idx  <= '0;
          iss_done <= 1'b0;
        end
        WAIT: begin
          if (wait_done) st <= READ;
          else           wait_cnt <= wait_cnt + 1'b1;
        end
        READ: begin
          if (exp.exp_valid && exp.exp_ready && exp.exp_last) begin
            st   <= IDLE;
            busy <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_cceip_64_sa_snap_ctrl.sv
// Scoreboard bench for the snapshot controller: directed triggers push expected
// strobes/beats into queues that independent monitors pop and compare.
module tb_cr_cceip_64_sa_snap_ctrl;
  import cr_cceip_64_sa_snap_ctrlPKG::*;

  typedef struct {
    int               idx;
    logic [CNT_W-1:0] data;
    logic             last;
    int               cyc;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [TMR_W-1:0]        cfg_period;
  logic                    sw_snap_req;
  logic                    sw_clear_req;
  logic                    sa_snap;
  logic                    sa_clear_live;
  logic [IDX_W-1:0]        rd_idx;
  logic [CNT_W-1:0]        rd_data;
  logic                    busy;
  logic [SA_OVERRUN_W-1:0] overrun_cnt;

  logic [CNT_W-1:0] data_base = '0;
  logic [CNT_W-1:0] data_mul  = 50'd3;

  int    cyc    = 0;
  int    n_vec  = 0;
  int    n_fail = 0;
  beat_t beat_q[$];
  int    snap_q[$];

  cr_cceip_64_sa_snap_ctrl_if exp_bus();

  cr_cceip_64_sa_snap_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_period    (cfg_period),
    .sw_snap_req   (sw_snap_req),
    .sw_clear_req  (sw_clear_req),
    .sa_snap       (sa_snap),
    .sa_clear_live (sa_clear_live),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .exp           (exp_bus),
    .busy          (busy),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Aggregator snapshot memory stand-in: value is a pure function of the read index.
  assign rd_data = data_base + CNT_W'(rd_idx) * data_mul;

  function automatic logic [CNT_W-1:0] cnt_val(input int i);
    return data_base + CNT_W'(i) * data_mul;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic applyStimulus(input logic snap, input logic clr, output int t);
    step();
    sw_snap_req  = snap;
    sw_clear_req = clr;
    t = cyc;
    step();
    sw_snap_req  = 1'b0;
    sw_clear_req = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_snapshot(input int snap_cyc, input bit beats_timed);
    beat_t b;
    snap_q.push_back(snap_cyc);
    for (int i = 0; i < N_CNTRS; i++) begin
      b.idx  = i;
      b.data = cnt_val(i);
      b.last = (i == N_CNTRS - 1);
      b.cyc  = beats_timed ? snap_cyc + 2 + i : -1;
      beat_q.push_back(b);
    end
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      step();
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    n_vec++;
    if (quiet < 3) begin
      n_fail++;
      $display("[TB] FAIL %s: busy=%b after %0d cycles, expected 0", name, busy, budget);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_sa_snap"},     64'(sa_snap),           64'd0);
    checkOutput({tag, "_clear_live"},  64'(sa_clear_live),     64'd0);
    checkOutput({tag, "_exp_valid"},   64'(exp_bus.exp_valid), 64'd0);
    checkOutput({tag, "_exp_last"},    64'(exp_bus.exp_last),  64'd0);
    checkOutput({tag, "_busy"},        64'(busy),              64'd0);
    checkOutput({tag, "_rd_idx"},      64'(rd_idx),            64'd0);
    checkOutput({tag, "_exp_idx"},     64'(exp_bus.exp_idx),   64'd0);
    checkOutput({tag, "_exp_data"},    64'(exp_bus.exp_data),  64'd0);
    checkOutput({tag, "_overrun_cnt"}, 64'(overrun_cnt),       64'd0);
  endtask

  // Beat monitor: every handshake must match the head of the expected-beat queue.
  always @(negedge clk) begin
    beat_t e;
    if (exp_bus.exp_valid === 1'b1 && exp_bus.exp_ready === 1'b1) begin
      n_vec++;
      if (beat_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL beat: unexpected idx=%0d data=%0h at cycle %0d, expected no beat",
                 exp_bus.exp_idx, exp_bus.exp_data, cyc);
      end else begin
        e = beat_q.pop_front();
        if (int'(exp_bus.exp_idx) != e.idx || exp_bus.exp_data !== e.data ||
            exp_bus.exp_last !== e.last || (e.cyc >= 0 && e.cyc != cyc)) begin
          n_fail++;
          $display("[TB] FAIL beat: got idx=%0d data=%0h last=%b cyc=%0d, expected idx=%0d data=%0h last=%b cyc=%0d",
                   exp_bus.exp_idx, exp_bus.exp_data, exp_bus.exp_last, cyc, e.idx, e.data, e.last, e.cyc);
        end
      end
    end
  end

  // Stall monitor: a beat offered without ready must be re-offered unchanged.
  bit               stall_prev = 1'b0;
  logic [IDX_W-1:0] p_idx;
  logic [CNT_W-1:0] p_data;
  logic             p_last;
  always @(negedge clk) begin
    if (stall_prev) begin
      n_vec++;
      if (exp_bus.exp_valid !== 1'b1 || exp_bus.exp_idx !== p_idx ||
          exp_bus.exp_data !== p_data || exp_bus.exp_last !== p_last) begin
        n_fail++;
        $display("[TB] FAIL stall_hold: got v=%b idx=%0d data=%0h last=%b, expected v=1 idx=%0d data=%0h last=%b",
                 exp_bus.exp_valid, exp_bus.exp_idx, exp_bus.exp_data, exp_bus.exp_last, p_idx, p_data, p_last);
      end
    end
    stall_prev = (exp_bus.exp_valid === 1'b1) && (exp_bus.exp_ready === 1'b0);
    p_idx  = exp_bus.exp_idx;
    p_data = exp_bus.exp_data;
    p_last = exp_bus.exp_last;
  end

  // Snap monitor: each sa_snap strobe must match the next expected cycle (-1 = any).
  always @(negedge clk) begin
    int e;
    if (sa_snap === 1'b1) begin
      n_vec++;
      if (snap_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL sa_snap: unexpected strobe at cycle %0d, expected none", cyc);
      end else begin
        e = snap_q.pop_front();
        if (e >= 0 && e != cyc) begin
          n_fail++;
          $display("[TB] FAIL sa_snap: strobe at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t, c;
    int stall_left;
    bit stalled, done;

    rst               = 1'b1;
    cfg_period        = '0;
    sw_snap_req       = 1'b0;
    sw_clear_req      = 1'b0;
    exp_bus.exp_ready = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) step();

    $display("[TB] basic readout");
    data_base = '0;
    data_mul  = 50'd3;
    applyStimulus(1'b1, 1'b0, t);
    expect_snapshot(t + 1, 1'b1);
    checkOutput("basic_busy_rise", 64'(busy), 64'd1);
    wait_until(t + 66);
    checkOutput("basic_last_cycle", 64'(exp_bus.exp_last), 64'd1);
    checkOutput("basic_busy_before_end", 64'(busy), 64'd1);
    step();
    checkOutput("basic_busy_fall", 64'(busy), 64'd0);
    wait_quiet("basic_idle", 20);

    $display("[TB] backpressure");
    data_base = 50'h2_AAAA_0000_0000;
    data_mul  = 50'd5;
    applyStimulus(1'b1, 1'b0, t);
    expect_snapshot(t + 1, 1'b0);
    stalled = 1'b0;
    stall_left = 0;
    done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      step();
      if (!busy) begin
        done = 1'b1;
      end else begin
        if (!stalled && exp_bus.exp_valid && exp_bus.exp_idx == IDX_W'(17)) begin
          stalled = 1'b1;
          stall_left = 20;
        end
        if (stall_left > 0) begin
          exp_bus.exp_ready = 1'b0;
          stall_left--;
        end else begin
          exp_bus.exp_ready = cyc[0];
        end
      end
    end
    exp_bus.exp_ready = 1'b1;
    checkOutput("bp_completed", 64'(done), 64'd1);
    checkOutput("bp_stall_seen", 64'(stalled), 64'd1);
    checkOutput("bp_beats_drained", 64'(beat_q.size()), 64'd0);

    // The pulse that starts the readout is the first of three; the other two land mid-readout.
    $display("[TB] overrun");
    data_base = 50'd1;
    data_mul  = 50'd7;
    applyStimulus(1'b1, 1'b0, t);
    expect_snapshot(t + 1, 1'b1);
    expect_snapshot(t + 68, 1'b1);
    wait_until(t + 19);
    applyStimulus(1'b1, 1'b0, c);
    wait_until(t + 29);
    applyStimulus(1'b1, 1'b0, c);
    wait_until(t + 40);
    checkOutput("overrun_one", 64'(overrun_cnt), 64'd1);
    wait_quiet("overrun_idle", 300);
    checkOutput("overrun_still_one", 64'(overrun_cnt), 64'd1);

    exp_bus.exp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, t);
    expect_snapshot(t + 1, 1'b0);
    expect_snapshot(-1, 1'b0);
    for (int i = 0; i < 301; i++) applyStimulus(1'b1, 1'b0, c);
    checkOutput("overrun_saturated", 64'(overrun_cnt), 64'd255);
    checkOutput("overrun_stuck_busy", 64'(busy), 64'd1);
    exp_bus.exp_ready = 1'b1;
    wait_quiet("overrun_drain", 400);
    checkOutput("overrun_hold_255", 64'(overrun_cnt), 64'd255);

    $display("[TB] simultaneous strobes");
    applyStimulus(1'b1, 1'b1, t);
    expect_snapshot(t + 1, 1'b1);
    checkOutput("both_sa_snap", 64'(sa_snap), 64'd1);
    checkOutput("both_clear_live", 64'(sa_clear_live), 64'd1);
    step();
    checkOutput("clear_single_cycle", 64'(sa_clear_live), 64'd0);
    wait_until(t + 19);
    applyStimulus(1'b0, 1'b1, c);
    checkOutput("clear_while_busy", 64'(sa_clear_live), 64'd1);
    step();
    checkOutput("clear_busy_drop", 64'(sa_clear_live), 64'd0);
    wait_quiet("strobe_idle", 200);

    $display("[TB] periodic timer");
    step();
    cfg_period = 32'd200;
    c = cyc;
    expect_snapshot(c + 200, 1'b1);
    expect_snapshot(c + 400, 1'b1);
    wait_until(c + 520);
    checkOutput("tmr_idle_before_reconf", 64'(busy), 64'd0);
    cfg_period = 32'd50;
    expect_snapshot(c + 521, 1'b1);
    expect_snapshot(c + 588, 1'b1);
    wait_until(c + 575);
    cfg_period = '0;
    wait_quiet("tmr_idle", 300);
    checkOutput("tmr_snaps_done", 64'(snap_q.size()), 64'd0);

    $display("[TB] reset mid-readout");
    data_base = 50'h1_0000_0000_0000;
    data_mul  = 50'd11;
    applyStimulus(1'b1, 1'b0, t);
    expect_snapshot(t + 1, 1'b1);
    wait_until(t + 33);
    checkOutput("rst_at_beat30", 64'(exp_bus.exp_idx), 64'd30);
    rst = 1'b1;
    step();
    beat_q.delete();
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (3) step();
    applyStimulus(1'b1, 1'b0, t);
    expect_snapshot(t + 1, 1'b1);
    wait_quiet("rst_restart_idle", 200);

    checkOutput("final_snap_q_empty", 64'(snap_q.size()), 64'd0);
    checkOutput("final_beat_q_empty", 64'(beat_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
